// File: rtl/parameters_pkg.sv
// Shared constants for the Ed448 point encoder.
//   DATA_WIDTH : field element width (Montgomery form, R = 2^DATA_WIDTH)
//   ENC_WIDTH  : width of the RFC 8032 point encoding
//   MUL_DIGIT  : digit width consumed per Montgomery multiplier iteration
//   P          : 2^448 - 2^224 - 1
//   P_MINUS_2  : inversion exponent (Fermat)
//   R_MOD_P    : Montgomery one, 2^448 mod P = 2^224 + 1
//   N_PRIME    : -P^-1 mod 2^MUL_DIGIT
package parameters_pkg;

    localparam int DATA_WIDTH = 448;
    localparam int ENC_WIDTH  = 456;
    localparam int MUL_DIGIT  = 112;

    localparam logic [DATA_WIDTH-1:0] P         = {{223{1'b1}}, 1'b0, {224{1'b1}}};
    localparam logic [DATA_WIDTH-1:0] P_MINUS_2 = P - 448'd2;
    localparam logic [DATA_WIDTH-1:0] R_MOD_P   = {{223{1'b0}}, 1'b1, {223{1'b0}}, 1'b1};

    // The low 224 bits of P are all ones, so P == -1 mod 2^d for any digit
    // width d <= 224 and the per-digit Montgomery factor collapses to 1.
    localparam logic [MUL_DIGIT-1:0] N_PRIME = MUL_DIGIT'(1);

endpackage

// File: rtl/mont_mul.sv
// Digit-serial Montgomery multiplier: r = a * b * 2^-DATA_WIDTH mod P.
// Consumes DIGIT bits of a per cycle (DATA_WIDTH/DIGIT iterations), then one
// cycle of conditional subtraction. Operands must be < P; r is fully reduced.
//   clk, rst_n : clock, async active-low reset
//   start      : 1-cycle request, sampled only while idle
//   a, b       : operands, captured on start
//   r          : result, valid with done and held until the next completion
//   done       : 1-cycle completion pulse
module mont_mul #(
    parameter int DATA_WIDTH = parameters_pkg::DATA_WIDTH,
    parameter int DIGIT      = parameters_pkg::MUL_DIGIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] r,
    output logic                  done
);
    import parameters_pkg::*;

    localparam int NDIG = DATA_WIDTH / DIGIT;
    localparam int TW   = DATA_WIDTH + DIGIT + 2;   // headroom for t + a_i*b + m*P
    localparam int SW   = DATA_WIDTH + 1;           // partial result stays < 2P
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [SW-1:0] PX = {1'b0, DATA_WIDTH'(P)};

    logic                  busy;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] a_sh;
    logic [DATA_WIDTH-1:0] b_r;
    logic [SW-1:0]         t_r;
    logic [TW-1:0]         u;
    logic [TW-1:0]         v;
    logic [DIGIT-1:0]      m;
    logic [SW-1:0]         t_nxt;
    logic [SW-1:0]         t_red;

    // One reduction step: add a_i*b, pick m so the low digit cancels, shift.
    always_comb begin
        u     = TW'(t_r) + TW'(a_sh[DIGIT-1:0]) * TW'(b_r);
        m     = u[DIGIT-1:0] * DIGIT'(N_PRIME);
        v     = u + TW'(m) * TW'(PX);
        t_nxt = SW'(v >> DIGIT);
        t_red = (t_r >= PX) ? t_r - PX : t_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
            a_sh <= '0;
            b_r  <= '0;
            t_r  <= '0;
            r    <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy <= 1'b1;
                    cnt  <= '0;
                    a_sh <= a;
                    b_r  <= b;
                    t_r  <= '0;
                end
            end else if (cnt == CW'(NDIG)) begin
                r    <= DATA_WIDTH'(t_red);
                done <= 1'b1;
                busy <= 1'b0;
            end else begin
                t_r  <= t_nxt;
                a_sh <= a_sh >> DIGIT;
                cnt  <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/point_encode.sv
// Ed448 point encoder: converts a projective point (X:Y:Z) in Montgomery
// form into the 57-byte RFC 8032 encoding. Z is inverted by Fermat
// exponentiation (left-to-right square-and-multiply) on one shared
// Montgomery multiplier, the affine coordinates are formed and taken out of
// the Montgomery domain, then y and the sign of x are packed.
//   clk, rst_n : clock, async active-low reset
//   start      : request, accepted only when idle
//   X, Y, Z    : projective point, captured on the accepted start
//   enc        : encoding, byte i = enc[8i+7:8i]; held until next start
//   busy       : high from accepted start through the done cycle
//   done       : 1-cycle pulse when enc/err are valid
//   err        : Z was zero (enc = 0)
module point_encode #(
    parameter int DATA_WIDTH = parameters_pkg::DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [DATA_WIDTH-1:0]                X,
    input  logic [DATA_WIDTH-1:0]                Y,
    input  logic [DATA_WIDTH-1:0]                Z,
    output logic [parameters_pkg::ENC_WIDTH-1:0] enc,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);
    import parameters_pkg::*;

    typedef enum logic [2:0] {
        IDLE, INV_SQ, INV_MUL, MUL_X, MUL_Y, CONV_X, CONV_Y, DONE
    } state_t;

    localparam logic [DATA_WIDTH-1:0] EXP   = DATA_WIDTH'(P_MINUS_2);
    localparam logic [DATA_WIDTH-1:0] ONE_M = DATA_WIDTH'(R_MOD_P);
    localparam logic [DATA_WIDTH-1:0] ONE   = DATA_WIDTH'(1);
    localparam logic [8:0]            K_TOP = 9'(DATA_WIDTH - 1);
    localparam int                    PAD_W = ENC_WIDTH - DATA_WIDTH - 1;

    state_t                state, state_n;
    logic [8:0]            k;
    logic [DATA_WIDTH-1:0] acc, xr, yr, zr;
    logic [DATA_WIDTH-1:0] op_a, op_b;
    logic [DATA_WIDTH-1:0] mul_a, mul_b, mul_r;
    logic                  mul_start, mul_done;
    logic                  pending;     // an operation has been issued and not yet returned
    logic                  uses_mul;
    logic                  op_done;

    // A mul done is only meaningful for an operation this FSM issued, which
    // keeps stray completions (e.g. in IDLE) from advancing anything.
    assign op_done = pending && mul_done;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    mont_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .r     (mul_r),
        .done  (mul_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = (Z == '0) ? DONE : INV_SQ;
            INV_SQ:  if (op_done) begin
                         if (EXP[k])         state_n = INV_MUL;
                         else if (k == '0)   state_n = MUL_X;
                     end
            INV_MUL: if (op_done) state_n = (k == '0) ? MUL_X : INV_SQ;
            MUL_X:   if (op_done) state_n = MUL_Y;
            MUL_Y:   if (op_done) state_n = CONV_X;
            CONV_X:  if (op_done) state_n = CONV_Y;
            CONV_Y:  if (op_done) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand selection per state. acc holds Zinv (Montgomery form) once the
    // exponent scan finishes; multiplying by plain 1 leaves the domain.
    always_comb begin
        op_a     = acc;
        op_b     = acc;
        uses_mul = 1'b1;
        case (state)
            INV_SQ:  begin op_a = acc; op_b = acc; end
            INV_MUL: begin op_a = acc; op_b = zr;  end
            MUL_X:   begin op_a = xr;  op_b = acc; end
            MUL_Y:   begin op_a = yr;  op_b = acc; end
            CONV_X:  begin op_a = xr;  op_b = ONE; end
            CONV_Y:  begin op_a = yr;  op_b = ONE; end
            default: uses_mul = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= '0;
            acc       <= '0;
            xr        <= '0;
            yr        <= '0;
            zr        <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            pending   <= 1'b0;
            enc       <= '0;
            err       <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            if (state == IDLE) begin
                pending <= 1'b0;
                if (start) begin
                    xr  <= X;
                    yr  <= Y;
                    zr  <= Z;
                    acc <= ONE_M;
                    k   <= K_TOP;
                    enc <= '0;
                    err <= (Z == '0);
                end
            end else if (uses_mul) begin
                if (!pending) begin
                    mul_a     <= op_a;
                    mul_b     <= op_b;
                    mul_start <= 1'b1;
                    pending   <= 1'b1;
                end else if (mul_done) begin
                    pending <= 1'b0;
                    case (state)
                        // k only moves once both halves of a set bit are done.
                        INV_SQ: begin
                            acc <= mul_r;
                            if (!EXP[k] && k != '0) k <= k - 9'd1;
                        end
                        INV_MUL: begin
                            acc <= mul_r;
                            if (k != '0) k <= k - 9'd1;
                        end
                        MUL_X, CONV_X: xr <= mul_r;
                        MUL_Y:         yr <= mul_r;
                        CONV_Y:        enc <= {xr[0], {PAD_W{1'b0}}, mul_r};
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
